mdu_16: RTL and testbench

Iterative 16-bit multiply/divide unit in the execute stage. It takes the two operands read from the 8×16 register file, runs a 16-step shift-add multiply or restoring divide, and returns the result to the register-file write port through a valid/ready writeback handshake. While it works, `busy` stalls issue.

---
 rtl/mdu_16_if.sv | 29 ++
 rtl/mdu_16.sv | 183 ++++++++++++++++++
 tb/tb_mdu_16.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_16_if.sv
// Issue and writeback port bundle of the iterative multiply/divide unit.
// The master side (issue logic / register file) drives the request and grant; the MDU is the slave.
interface mdu_16_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
);
  logic              start;
  logic [1:0]        op;
  logic [WIDTH-1:0]  src_a;
  logic [WIDTH-1:0]  src_b;
  logic [ADDR_W-1:0] dest;
  logic              busy;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_dest;
  logic [WIDTH-1:0]  wb_data;
  logic              div_by_zero;
  logic              op_err;

  modport master (
    output start, op, src_a, src_b, dest, wb_ready,
    input  busy, wb_valid, wb_dest, wb_data, div_by_zero, op_err
  );

  modport slave (
    input  start, op, src_a, src_b, dest, wb_ready,
    output busy, wb_valid, wb_dest, wb_data, div_by_zero, op_err
  );
endinterface

// File: rtl/mdu_16.sv
// Iterative 16-step shift-add multiplier / restoring divider with valid/ready writeback.
// Define MDU_DIV_EN to compile in the divide datapath; otherwise divide ops retire at once with op_err.
module mdu_16 #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  mdu_16_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIVU = 2'b10,
    OP_REMU = 2'b11
  } op_t;

  state_t              state_q, state_d;
  op_t                 op_q;
  logic [WIDTH-1:0]    a_q;
  logic [ADDR_W-1:0]   dest_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*WIDTH-1:0]  prod_q, prod_step;
  logic [WIDTH:0]      mac_sum;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                wb_valid_q;
  logic                accept, last_step, div_skip;

  assign accept    = (state_q == IDLE) && bus.start;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // Multiply step: conditionally add the multiplicand into the upper half, then shift the
  // 33-bit {carry, upper, lower} right by one so the multiplier bits drain out of the bottom.
  always_comb begin
    mac_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
    prod_step = {mac_sum, prod_q[WIDTH-1:1]};
  end

`ifdef MDU_DIV_EN
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_q, rem_step;
  logic [WIDTH-1:0] quot_q, quot_step;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic             dbz_q, dbz_d;

  // Restoring divide step; a zero divisor always "fits", which naturally yields an all-ones
  // quotient and a remainder equal to the dividend.
  always_comb begin
    rem_shift = {rem_q, quot_q[WIDTH-1]};
    rem_ge    = (rem_shift >= {1'b0, b_q});
    rem_step  = rem_ge ? WIDTH'(rem_shift - {1'b0, b_q}) : rem_shift[WIDTH-1:0];
    quot_step = {quot_q[WIDTH-2:0], rem_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q    <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      dbz_q  <= 1'b0;
    end else begin
      if (accept) begin
        b_q    <= bus.src_b;
        rem_q  <= '0;
        quot_q <= bus.src_a;
      end else if (state_q == RUN) begin
        rem_q  <= rem_step;
        quot_q <= quot_step;
      end
      if (state_q == RUN && state_d == DONE) begin
        dbz_q <= dbz_d;
      end
    end
  end

  assign div_skip        = 1'b0;
  assign bus.div_by_zero = dbz_q;
  assign bus.op_err      = 1'b0;
`else
  logic op_err_q, op_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_err_q <= 1'b0;
    end else if (state_q == RUN && state_d == DONE) begin
      op_err_q <= op_err_d;
    end
  end

  assign div_skip        = (state_q == RUN) && op_q[1];
  assign bus.div_by_zero = 1'b0;
  assign bus.op_err      = op_err_q;
`endif

  // NOTE: every output of a combinational block gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    result_d = '0;
`ifdef MDU_DIV_EN
    dbz_d    = 1'b0;
`else
    op_err_d = 1'b0;
`endif
    case (op_q)
      OP_MUL:  result_d = prod_step[WIDTH-1:0];
      OP_MULH: result_d = prod_step[2*WIDTH-1:WIDTH];
      default: begin
`ifdef MDU_DIV_EN
        result_d = (op_q == OP_DIVU) ? quot_step : rem_step;
        dbz_d    = (b_q == '0);
`else
        op_err_d = 1'b1;
`endif
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start)              state_d = RUN;
      RUN:  if (last_step || div_skip)  state_d = DONE;
      DONE: if (bus.wb_ready || dest_q == '0) state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the datapath registers are reset along with control so an aborted transaction
  // leaves the writeback outputs at their reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_MUL;
      a_q        <= '0;
      dest_q     <= '0;
      cnt_q      <= '0;
      prod_q     <= '0;
      result_q   <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= op_t'(bus.op);
        a_q    <= bus.src_a;
        dest_q <= bus.dest;
        cnt_q  <= '0;
        prod_q <= {{WIDTH{1'b0}}, bus.src_b};
      end else if (state_q == RUN) begin
        cnt_q  <= cnt_q + CNT_W'(1);
        prod_q <= prod_step;
      end
      if (state_q == RUN && state_d == DONE) begin
        result_q <= result_d;
      end
      // Writes to register 0 are dropped: DONE is passed through without a valid.
      wb_valid_q <= (state_d == DONE) && (dest_q != '0);
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_dest  = dest_q;
  assign bus.wb_data  = result_q;

endmodule

// File: tb/tb_mdu_16.sv
// Self-checking bench for mdu_16: vector table plus random vectors through a scoreboard,
// and hand sequences for writeback stall, reset abort and dest=0 discard.
module tb_mdu_16;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_16_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();
  mdu_16 #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  dest;
    logic [15:0] data;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  dest;
    logic        dbz;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] op, input logic [2:0] d,
                              input logic [15:0] data, input logic dbz);
    exp_t e;
    e.data = data; e.dest = d; e.dbz = dbz; e.err = 1'b0; e.lat = 16;
`ifndef MDU_DIV_EN
    if (op[1]) begin
      e.data = 16'h0000; e.dbz = 1'b0; e.err = 1'b1; e.lat = 1;
    end
`endif
    return e;
  endfunction

  function automatic logic [15:0] model_data(input logic [1:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
    logic [31:0] p;
    p = {16'h0, a} * {16'h0, b};
    case (op)
      2'b00:   return p[15:0];
      2'b01:   return p[31:16];
      2'b10:   return (b == 16'h0) ? 16'hFFFF : a / b;
      default: return (b == 16'h0) ? a : a % b;
    endcase
  endfunction

  // Drive one request on the next edge; operands are scrambled afterwards (don't-care).
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] d, input bit push, input exp_t e);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b; bus.dest = d;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.src_a = 16'($urandom); bus.src_b = 16'($urandom); bus.dest = 3'($urandom);
    check("busy_after_accept", {31'b0, bus.busy}, 32'd1);
  endtask

  task automatic await_wb(output int n, output bit ok);
    n = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.wb_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Wait for the result, compare against the scoreboard head, then check the retire edge.
  task automatic complete(input string tag);
    int   n;
    bit   ok;
    exp_t e;
    await_wb(n, ok);
    check({tag, "_wb_valid_seen"}, {31'b0, ok}, 32'd1);
    if (ok && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_latency"}, n, e.lat);
      check({tag, "_data"}, {16'b0, bus.wb_data}, {16'b0, e.data});
      check({tag, "_dest"}, {29'b0, bus.wb_dest}, {29'b0, e.dest});
      check({tag, "_dbz"}, {31'b0, bus.div_by_zero}, {31'b0, e.dbz});
      check({tag, "_op_err"}, {31'b0, bus.op_err}, {31'b0, e.err});
      @(posedge clk); #1;
      check({tag, "_retire_busy"}, {31'b0, bus.busy}, 32'd0);
      check({tag, "_retire_valid"}, {31'b0, bus.wb_valid}, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   n;
    bit   ok, seen;
    exp_t e;
    logic [1:0]  rop;
    logic [15:0] ra, rb;
    logic [2:0]  rd;

    vecs[0]  = '{op: 2'b00, a: 16'd300,  b: 16'd300,  dest: 3'd3, data: 16'h5F90, dbz: 1'b0};
    vecs[1]  = '{op: 2'b01, a: 16'd300,  b: 16'd300,  dest: 3'd3, data: 16'h0001, dbz: 1'b0};
    vecs[2]  = '{op: 2'b10, a: 16'd1000, b: 16'd7,    dest: 3'd5, data: 16'h008E, dbz: 1'b0};
    vecs[3]  = '{op: 2'b11, a: 16'd1000, b: 16'd7,    dest: 3'd5, data: 16'h0006, dbz: 1'b0};
    vecs[4]  = '{op: 2'b10, a: 16'h00AB, b: 16'h0000, dest: 3'd5, data: 16'hFFFF, dbz: 1'b1};
    vecs[5]  = '{op: 2'b11, a: 16'h00AB, b: 16'h0000, dest: 3'd5, data: 16'h00AB, dbz: 1'b1};
    vecs[6]  = '{op: 2'b00, a: 16'hFFFF, b: 16'hFFFF, dest: 3'd7, data: 16'h0001, dbz: 1'b0};
    vecs[7]  = '{op: 2'b01, a: 16'hFFFF, b: 16'hFFFF, dest: 3'd7, data: 16'hFFFE, dbz: 1'b0};
    vecs[8]  = '{op: 2'b10, a: 16'd5,    b: 16'd9,    dest: 3'd1, data: 16'h0000, dbz: 1'b0};
    vecs[9]  = '{op: 2'b11, a: 16'd5,    b: 16'd9,    dest: 3'd1, data: 16'h0005, dbz: 1'b0};
    vecs[10] = '{op: 2'b10, a: 16'hFFFF, b: 16'd1,    dest: 3'd2, data: 16'hFFFF, dbz: 1'b0};
    vecs[11] = '{op: 2'b00, a: 16'h0000, b: 16'h1234, dest: 3'd6, data: 16'h0000, dbz: 1'b0};

    bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0; bus.dest = '0;
    bus.wb_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",     {31'b0, bus.busy},        32'd0);
    check("reset_wb_valid", {31'b0, bus.wb_valid},    32'd0);
    check("reset_wb_dest",  {29'b0, bus.wb_dest},     32'd0);
    check("reset_wb_data",  {16'b0, bus.wb_data},     32'd0);
    check("reset_dbz",      {31'b0, bus.div_by_zero}, 32'd0);
    check("reset_op_err",   {31'b0, bus.op_err},      32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors, issued back-to-back at the minimum interval.
    for (int i = 0; i < 12; i++) begin
      e = mk(vecs[i].op, vecs[i].dest, vecs[i].data, vecs[i].dbz);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, 1'b1, e);
      complete($sformatf("vec%0d", i));
    end

    // Random vectors checked against the arithmetic model.
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 16'($urandom);
      rb  = (i == 0) ? 16'h0000 : 16'($urandom);
      rd  = 3'($urandom_range(1, 7));
      e = mk(rop, rd, model_data(rop, ra, rb), rop[1] && (rb == 16'h0));
      issue(rop, ra, rb, rd, 1'b1, e);
      complete($sformatf("rnd%0d", i));
    end

    // Writeback stall: result held, busy high, a start pulse in the window is dropped.
    bus.wb_ready = 1'b0;
    e = mk(2'b00, 3'd3, 16'h5F90, 1'b0);
    issue(2'b00, 16'd300, 16'd300, 3'd3, 1'b0, e);
    await_wb(n, ok);
    check("stall_wb_valid_seen", {31'b0, ok}, 32'd1);
    check("stall_latency", n, 16);
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 1);
      bus.op = 2'b01; bus.src_a = 16'd7; bus.src_b = 16'd9; bus.dest = 3'd6;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check($sformatf("stall%0d_valid", i), {31'b0, bus.wb_valid}, 32'd1);
      check($sformatf("stall%0d_busy", i),  {31'b0, bus.busy},     32'd1);
      check($sformatf("stall%0d_data", i),  {16'b0, bus.wb_data},  {16'b0, e.data});
      check($sformatf("stall%0d_dest", i),  {29'b0, bus.wb_dest},  {29'b0, e.dest});
    end
    bus.wb_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_retire_busy",  {31'b0, bus.busy},     32'd0);
    check("stall_retire_valid", {31'b0, bus.wb_valid}, 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.busy || bus.wb_valid) seen = 1'b1;
    end
    check("stall_start_not_queued", {31'b0, seen}, 32'd0);

    // dest=0: computation runs, no valid, busy drops after E17, next start accepted.
    issue(2'b00, 16'd300, 16'd300, 3'd0, 1'b0, e);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.wb_valid) seen = 1'b1;
      if (!bus.busy) break;
    end
    check("dest0_busy_fall_edge", n, 17);
    check("dest0_no_valid", {31'b0, seen}, 32'd0);
    e = mk(2'b00, 3'd2, 16'h3579, 1'b0);
    issue(2'b00, 16'h3579, 16'h0001, 3'd2, 1'b1, e);
    complete("after_dest0");

    // Reset at step 8 of a multiply aborts it with no later writeback.
    issue(2'b00, 16'h1234, 16'h0101, 3'd4, 1'b0, e);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy",     {31'b0, bus.busy},     32'd0);
    check("abort_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
    check("abort_wb_data",  {16'b0, bus.wb_data},  32'd0);
    #3;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.wb_valid || bus.busy) seen = 1'b1;
    end
    check("abort_no_late_valid", {31'b0, seen}, 32'd0);

    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
